// File: rtl/number_sched_pkg.sv
// Shared types and constants for number_engine_scheduler and its round-robin arbiter.
package number_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StWait,
    StResp
  } sched_state_e;

  localparam int unsigned DefNumReq        = 4;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefTimeoutCycles = 1024;

  // Width of a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr_i, wrapping at NUM_REQ.
module rr_arbiter
  import number_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  parameter int unsigned IdW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     idx_o
);

  logic        found;
  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap so non-power-of-two NUM_REQ never indexes a missing requester.
      cand = 32'(ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (en_i && !found && req_i[cand[IdW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[cand[IdW-1:0]]   = 1'b1;
        idx_o                  = cand[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/number_engine_scheduler.sv
// Shares one go/done number engine among NUM_REQ requesters with round-robin arbitration.
// Define NUMBER_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module number_engine_scheduler
  import number_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DefNumReq,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_number_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         eng_go_o,
  output logic [DATA_W-1:0]            eng_number_o,
  input  logic                         eng_done_i,
  input  logic                         eng_result_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [id_width(NUM_REQ)-1:0] resp_id_o,
  output logic                         resp_result_o,
  output logic                         resp_timeout_o,
  output logic                         busy_o
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("number_engine_scheduler: parameter out of range");
  end

  sched_state_e       state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     id_q, id_d;
  logic [DATA_W-1:0]  num_q, num_d;
  logic               result_q, result_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IdW-1:0]     gnt_idx;

`ifdef NUMBER_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            cnt_expired;
  assign cnt_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IdW    (IdW)
  ) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (state_q == StIdle),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    num_d    = num_q;
    result_d = result_q;
`ifdef NUMBER_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          state_d = StLaunch;
          id_d    = gnt_idx;
          num_d   = req_number_i[32'(gnt_idx) * DATA_W +: DATA_W];
          ptr_d   = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      StLaunch: begin
        state_d = StWait;
`ifdef NUMBER_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StWait: begin
        if (eng_done_i) begin
          state_d  = StResp;
          result_d = eng_result_i;
`ifdef NUMBER_SCHED_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cnt_expired) begin
          state_d   = StResp;
          result_d  = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      num_q    <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      num_q    <= num_d;
      result_q <= result_d;
    end
  end

`ifdef NUMBER_SCHED_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign resp_timeout_o = timeout_q;
`else
  assign resp_timeout_o = 1'b0;
`endif

  assign req_ready_o   = gnt;
  assign eng_go_o      = (state_q == StLaunch);
  assign eng_number_o  = num_q;
  assign resp_valid_o  = (state_q == StResp);
  assign resp_id_o     = id_q;
  assign resp_result_o = result_q;
  assign busy_o        = (state_q != StIdle);

endmodule
